regfile_sb: RTL and testbench

//  8 x 16-bit register file with integrated busy-bit scoreboard; receiving end of the

---
 rtl/regfile_sb.sv | 85 ++++++++
 tb/tb_regfile_sb.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_sb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : regfile_sb                                                    |
// | Brief    : 8x16 register file with busy-bit scoreboard, write bypass and |
// |            RAW/WAW stall generation for a single-issue decode stage.     |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module regfile_sb #(
    parameter int DATA_W = 16,
    parameter int NREG   = 8,
    parameter int ADDR_W = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rd_addr1,
    input  logic              rd_use1,
    input  logic [ADDR_W-1:0] rd_addr2,
    input  logic              rd_use2,
    output logic [DATA_W-1:0] rd_data1,
    output logic [DATA_W-1:0] rd_data2,
    input  logic              iss_valid,
    input  logic              iss_dst_en,
    input  logic [ADDR_W-1:0] iss_dst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              stall,
    output logic              err
);

    logic [DATA_W-1:0] r_regs_q [NREG];
    logic [DATA_W-1:0] w_regs_d [NREG];
    logic [NREG-1:0]   r_busy_q;
    logic [NREG-1:0]   w_busy_d;

    logic w_clr1;
    logic w_clr2;
    logic w_clr_dst;
    logic w_accept;

    always_comb begin
        w_clr1    = wr_en && (wr_addr == rd_addr1);
        w_clr2    = wr_en && (wr_addr == rd_addr2);
        w_clr_dst = wr_en && (wr_addr == iss_dst);

        rd_data1  = w_clr1 ? wr_data : r_regs_q[rd_addr1];
        rd_data2  = w_clr2 ? wr_data : r_regs_q[rd_addr2];

        // A write retiring this cycle resolves the hazard it would otherwise cause.
        stall     = iss_valid && (
                        (rd_use1    && r_busy_q[rd_addr1] && !w_clr1) ||
                        (rd_use2    && r_busy_q[rd_addr2] && !w_clr2) ||
                        (iss_dst_en && r_busy_q[iss_dst]  && !w_clr_dst));
        w_accept  = iss_valid && !stall;

        err       = wr_en && !r_busy_q[wr_addr];
    end

    always_comb begin
        w_regs_d = r_regs_q;
        w_busy_d = r_busy_q;
        if (wr_en) begin
            w_regs_d[wr_addr] = wr_data;
            w_busy_d[wr_addr] = 1'b0;
        end
        // Set after clear: a new producer supersedes the retiring one.
        if (w_accept && iss_dst_en) begin
            w_busy_d[iss_dst] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs_q[i] <= '0;
            end
            r_busy_q <= '0;
        end else begin
            r_regs_q <= w_regs_d;
            r_busy_q <= w_busy_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_regfile_sb                                                 |
// | Brief    : Directed and model-based checks for regfile_sb.               |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  rd_addr1, rd_addr2, iss_dst, wr_addr;
    logic        rd_use1, rd_use2, iss_valid, iss_dst_en, wr_en;
    logic [15:0] rd_data1, rd_data2, wr_data;
    logic        stall, err;

    int errors = 0;
    int checks = 0;

    logic [15:0] m_regs [8];
    logic [7:0]  m_busy;

    always #5 clk = ~clk;

    regfile_sb dut (
        .clk        (clk),
        .rst        (rst),
        .rd_addr1   (rd_addr1),
        .rd_use1    (rd_use1),
        .rd_addr2   (rd_addr2),
        .rd_use2    (rd_use2),
        .rd_data1   (rd_data1),
        .rd_data2   (rd_data2),
        .iss_valid  (iss_valid),
        .iss_dst_en (iss_dst_en),
        .iss_dst    (iss_dst),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .stall      (stall),
        .err        (err)
    );

    task automatic idle();
        rst = 1'b0; rd_addr1 = 3'd0; rd_use1 = 1'b0; rd_addr2 = 3'd0; rd_use2 = 1'b0;
        iss_valid = 1'b0; iss_dst_en = 1'b0; iss_dst = 3'd0;
        wr_en = 1'b0; wr_addr = 3'd0; wr_data = 16'h0;
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic test_reset();
        idle();
        rst = 1'b1; wr_en = 1'b1; wr_addr = 3'd2; wr_data = 16'h1234;
        tick();
        idle();
        for (int i = 0; i < 8; i++) begin
            rd_addr1 = 3'(i); rd_addr2 = 3'(7 - i);
            settle();
            checks++;
            if (rd_data1 !== 16'h0) begin
                errors++; $display("FAIL reset_rd1 r%0d got=%h exp=0000", i, rd_data1);
            end
            checks++;
            if (rd_data2 !== 16'h0) begin
                errors++; $display("FAIL reset_rd2 r%0d got=%h exp=0000", 7 - i, rd_data2);
            end
        end
        checks++;
        if (stall !== 1'b0 || err !== 1'b0) begin
            errors++; $display("FAIL reset_flags stall=%b err=%b exp=0/0", stall, err);
        end
    endtask

    task automatic test_raw();
        idle();
        iss_valid = 1'b1; iss_dst_en = 1'b1; iss_dst = 3'd3;
        settle();
        checks++;
        if (stall !== 1'b0) begin
            errors++; $display("FAIL raw_issue stall=%b exp=0", stall);
        end
        tick();
        idle();
        iss_valid = 1'b1; rd_addr1 = 3'd3; rd_use1 = 1'b1;
        settle();
        checks++;
        if (stall !== 1'b1) begin
            errors++; $display("FAIL raw_stall stall=%b exp=1", stall);
        end
        rd_use1 = 1'b0;
        settle();
        checks++;
        if (stall !== 1'b0) begin
            errors++; $display("FAIL raw_unused stall=%b exp=0", stall);
        end
        rd_addr2 = 3'd3; rd_use2 = 1'b1;
        settle();
        checks++;
        if (stall !== 1'b1) begin
            errors++; $display("FAIL raw_stall2 stall=%b exp=1", stall);
        end
        tick();
    endtask

    task automatic test_bypass();
        idle();
        iss_valid = 1'b1; rd_addr1 = 3'd3; rd_use1 = 1'b1;
        wr_en = 1'b1; wr_addr = 3'd3; wr_data = 16'hBEEF;
        settle();
        checks++;
        if (stall !== 1'b0 || rd_data1 !== 16'hBEEF || err !== 1'b0) begin
            errors++;
            $display("FAIL bypass stall=%b rd1=%h err=%b exp=0/beef/0", stall, rd_data1, err);
        end
        tick();
        wr_en = 1'b0;
        settle();
        checks++;
        if (stall !== 1'b0 || rd_data1 !== 16'hBEEF) begin
            errors++; $display("FAIL bypass_after stall=%b rd1=%h exp=0/beef", stall, rd_data1);
        end
        tick();
    endtask

    task automatic test_waw();
        idle();
        iss_valid = 1'b1; iss_dst_en = 1'b1; iss_dst = 3'd5;
        tick();
        settle();
        checks++;
        if (stall !== 1'b1) begin
            errors++; $display("FAIL waw_stall stall=%b exp=1", stall);
        end
        wr_en = 1'b1; wr_addr = 3'd5; wr_data = 16'h5555;
        settle();
        checks++;
        if (stall !== 1'b0 || err !== 1'b0) begin
            errors++; $display("FAIL waw_accept stall=%b err=%b exp=0/0", stall, err);
        end
        tick();
        idle();
        iss_valid = 1'b1; rd_addr1 = 3'd5; rd_use1 = 1'b1;
        settle();
        checks++;
        if (stall !== 1'b1 || rd_data1 !== 16'h5555) begin
            errors++; $display("FAIL waw_still_busy stall=%b rd1=%h exp=1/5555", stall, rd_data1);
        end
        idle();
        wr_en = 1'b1; wr_addr = 3'd5; wr_data = 16'h5A5A;
        settle();
        checks++;
        if (err !== 1'b0) begin
            errors++; $display("FAIL waw_retire err=%b exp=0", err);
        end
        tick();
    endtask

    task automatic test_err();
        idle();
        wr_en = 1'b1; wr_addr = 3'd6; wr_data = 16'h6666;
        settle();
        checks++;
        if (err !== 1'b1) begin
            errors++; $display("FAIL err_flag err=%b exp=1", err);
        end
        tick();
        idle();
        rd_addr2 = 3'd6;
        settle();
        checks++;
        if (rd_data2 !== 16'h6666 || err !== 1'b0) begin
            errors++; $display("FAIL err_write rd2=%h err=%b exp=6666/0", rd_data2, err);
        end
    endtask

    task automatic test_same_index();
        idle();
        rd_addr1 = 3'd5; rd_addr2 = 3'd5;
        settle();
        checks++;
        if (rd_data1 !== 16'h5A5A || rd_data2 !== 16'h5A5A) begin
            errors++; $display("FAIL same_idx rd1=%h rd2=%h exp=5a5a/5a5a", rd_data1, rd_data2);
        end
        wr_en = 1'b1; wr_addr = 3'd5; wr_data = 16'hC0DE;
        settle();
        checks++;
        if (rd_data1 !== 16'hC0DE || rd_data2 !== 16'hC0DE) begin
            errors++; $display("FAIL same_idx_byp rd1=%h rd2=%h exp=c0de/c0de", rd_data1, rd_data2);
        end
        tick();
        idle();
    endtask

    task automatic test_random();
        logic [15:0] e_rd1, e_rd2;
        logic        e_stall, e_err, e_acc;
        int          bad = 0;
        // Resynchronise the model with a known state.
        idle(); rst = 1'b1; tick(); idle();
        for (int k = 0; k < 8; k++) m_regs[k] = 16'h0;
        m_busy = 8'h0;
        for (int cyc = 0; cyc < 300; cyc++) begin
            rst        = (cyc == 150);
            iss_valid  = ($urandom_range(0, 3) != 0);
            iss_dst_en = $urandom_range(0, 1) == 1;
            iss_dst    = 3'($urandom_range(0, 7));
            rd_addr1   = 3'($urandom_range(0, 7));
            rd_addr2   = ($urandom_range(0, 3) == 0) ? rd_addr1 : 3'($urandom_range(0, 7));
            rd_use1    = $urandom_range(0, 1) == 1;
            rd_use2    = $urandom_range(0, 1) == 1;
            wr_en      = $urandom_range(0, 1) == 1;
            wr_addr    = 3'($urandom_range(0, 7));
            wr_data    = 16'($urandom);
            settle();
            e_rd1   = (wr_en && wr_addr == rd_addr1) ? wr_data : m_regs[rd_addr1];
            e_rd2   = (wr_en && wr_addr == rd_addr2) ? wr_data : m_regs[rd_addr2];
            e_err   = wr_en && !m_busy[wr_addr];
            e_stall = 1'b0;
            if (iss_valid) begin
                if (rd_use1 && m_busy[rd_addr1] && !(wr_en && wr_addr == rd_addr1)) e_stall = 1'b1;
                if (rd_use2 && m_busy[rd_addr2] && !(wr_en && wr_addr == rd_addr2)) e_stall = 1'b1;
                if (iss_dst_en && m_busy[iss_dst] && !(wr_en && wr_addr == iss_dst)) e_stall = 1'b1;
            end
            e_acc = iss_valid && !e_stall;
            checks++;
            if (rd_data1 !== e_rd1 || rd_data2 !== e_rd2 || stall !== e_stall || err !== e_err) begin
                errors++; bad++;
                if (bad <= 10)
                    $display("FAIL rand cyc=%0d rd1=%h/%h rd2=%h/%h stall=%b/%b err=%b/%b (got/exp)",
                             cyc, rd_data1, e_rd1, rd_data2, e_rd2, stall, e_stall, err, e_err);
            end
            if (rst) begin
                for (int k = 0; k < 8; k++) m_regs[k] = 16'h0;
                m_busy = 8'h0;
            end else begin
                if (wr_en) begin
                    m_regs[wr_addr] = wr_data;
                    m_busy[wr_addr] = 1'b0;
                end
                if (e_acc && iss_dst_en) m_busy[iss_dst] = 1'b1;
            end
            tick();
            if (cyc == 150) begin
                idle();
                for (int k = 0; k < 8; k++) begin
                    iss_valid = 1'b1; rd_use1 = 1'b1; rd_addr1 = 3'(k);
                    iss_dst_en = 1'b1; iss_dst = 3'(k);
                    settle();
                    checks++;
                    if (stall !== 1'b0 || rd_data1 !== 16'h0) begin
                        errors++;
                        $display("FAIL rand_rst r%0d stall=%b rd1=%h exp=0/0000", k, stall, rd_data1);
                    end
                end
                idle();
            end
        end
    endtask

    initial begin
        idle();
        test_reset();
        test_raw();
        test_bypass();
        test_waw();
        test_err();
        test_same_index();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
